// File: rtl/rom_ram_pkg.sv
// Shared definitions for the ROM/RAM copy sequencer
// and the memories it drives.
package rom_ram_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COPY   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/rom_copy_ctrl_if.sv
// Host handshake plus ROM and RAM buses owned by
// the copy sequencer.
interface rom_copy_ctrl_if
  import rom_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic                     start;
  logic                     busy;
  logic                     done;
  logic [ADDR_W+DATA_W-1:0] sum;
  logic                     mismatch;
  logic [ADDR_W-1:0]        err_addr;

  logic [ADDR_W-1:0]        rom_addr;
  logic [DATA_W-1:0]        rom_data;

  logic                     ram_we;
  logic [ADDR_W-1:0]        ram_addr;
  logic [DATA_W-1:0]        ram_wdata;
  logic [DATA_W-1:0]        ram_rdata;

  modport master (
    input  start,
    input  rom_data,
    input  ram_rdata,
    output busy,
    output done,
    output sum,
    output mismatch,
    output err_addr,
    output rom_addr,
    output ram_we,
    output ram_addr,
    output ram_wdata
  );

  modport slave (
    output start,
    output rom_data,
    output ram_rdata,
    input  busy,
    input  done,
    input  sum,
    input  mismatch,
    input  err_addr,
    input  rom_addr,
    input  ram_we,
    input  ram_addr,
    input  ram_wdata
  );

endinterface

// File: rtl/rom_copy_ctrl.sv
// Copies the ROM image into RAM, optionally reads it
// back against the ROM, and accumulates a checksum.
module rom_copy_ctrl
  import rom_ram_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter bit VERIFY_EN = 1'b1
)(
  input  logic            clk,
  input  logic            rst,
  rom_copy_ctrl_if.master bus
);

  localparam int SUM_W = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_idx;
  logic [SUM_W-1:0]    r_sum;
  logic                r_mis;
  logic [ADDR_W-1:0]   r_err;
  logic                w_last;
  logic                w_bad;

  assign w_last = (r_idx == LAST);
  assign w_bad  = (bus.ram_rdata != bus.rom_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.start) w_next = ST_COPY;
      end
      ST_COPY: begin
        if (w_last) w_next = VERIFY_EN ? ST_VERIFY : ST_DONE;
      end
      ST_VERIFY: begin
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.ram_we    = 1'b0;
    bus.rom_addr  = '0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    unique case (r_state)
      ST_COPY: begin
        bus.busy      = 1'b1;
        bus.ram_we    = 1'b1;
        bus.rom_addr  = r_idx;
        bus.ram_addr  = r_idx;
        bus.ram_wdata = bus.rom_data;
      end
      ST_VERIFY: begin
        bus.busy     = 1'b1;
        bus.rom_addr = r_idx;
        bus.ram_addr = r_idx;
      end
      ST_DONE: begin
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  // idx wraps naturally to 0 at the end of each pass
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
      r_sum <= '0;
      r_mis <= 1'b0;
      r_err <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_idx <= '0;
            r_sum <= '0;
            r_mis <= 1'b0;
            r_err <= '0;
          end
        end
        ST_COPY: begin
          r_sum <= r_sum + {{ADDR_W{1'b0}}, bus.rom_data};
          r_idx <= r_idx + 1'b1;
        end
        ST_VERIFY: begin
          if (w_bad) begin
            r_mis <= 1'b1;
            if (!r_mis) r_err <= r_idx;
          end
          r_idx <= r_idx + 1'b1;
        end
        ST_DONE: begin
          r_idx <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.sum      = r_sum;
  assign bus.mismatch = r_mis;
  assign bus.err_addr = r_err;

endmodule
